// File: rtl/gshare_bht.sv
// gshare branch direction predictor: saturating counters indexed by PC ^ GHR, speculative history, mispredict restore.
// Optional macro GSHARE_BHT_WR_BYPASS_EN forwards a same-cycle, same-index update result to the prediction.
module gshare_bht #(
  parameter int ENTRIES = 256,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 8,
  parameter int PC_LSB  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid_i,
  input  logic [31:0]      pred_pc_i,
  output logic             pred_resp_valid_o,
  output logic             pred_taken_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic [GHR_W-1:0] upd_ghr_i,
  input  logic             upd_taken_i,
  input  logic             upd_mispred_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

  logic [CTR_W-1:0] r_ctr [ENTRIES];
  logic [GHR_W-1:0] r_ghr;
  logic             r_resp_valid;
  logic             r_taken;
  logic [GHR_W-1:0] r_pred_ghr;

  logic [IDX_W-1:0] w_pred_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic [CTR_W-1:0] w_upd_old;
  logic [CTR_W-1:0] w_upd_new;
  logic [CTR_W-1:0] w_pred_ctr;
  logic             w_pred_taken;
  logic [GHR_W-1:0] w_ghr_next;
  logic             w_unused;

  assign w_pred_idx = pred_pc_i[PC_LSB +: IDX_W] ^ IDX_W'(r_ghr);
  assign w_upd_idx  = upd_pc_i[PC_LSB +: IDX_W] ^ IDX_W'(upd_ghr_i);
  assign w_upd_old  = r_ctr[w_upd_idx];

  always_comb begin
    w_upd_new = w_upd_old;
    if (upd_taken_i) begin
      if (w_upd_old != CTR_MAX) w_upd_new = w_upd_old + CTR_W'(1);
    end else begin
      if (w_upd_old != '0) w_upd_new = w_upd_old - CTR_W'(1);
    end
  end

`ifdef GSHARE_BHT_WR_BYPASS_EN
  assign w_pred_ctr = (upd_valid_i && (w_upd_idx == w_pred_idx)) ? w_upd_new : r_ctr[w_pred_idx];
`else
  assign w_pred_ctr = r_ctr[w_pred_idx];
`endif

  assign w_pred_taken = w_pred_ctr[CTR_W-1];

  // Mispredict restore takes priority; a same-cycle speculative shift is dropped.
  always_comb begin
    w_ghr_next = r_ghr;
    if (upd_valid_i && upd_mispred_i) begin
      w_ghr_next = (upd_ghr_i << 1) | GHR_W'(upd_taken_i);
    end else if (pred_valid_i) begin
      w_ghr_next = (r_ghr << 1) | GHR_W'(w_pred_taken);
    end
  end

  // Handshake: pred_valid_i is a one-cycle request with no ready (always accepted);
  // pred_resp_valid_o pulses exactly one cycle later and has no back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_INIT;
      r_ghr        <= '0;
      r_resp_valid <= 1'b0;
      r_taken      <= 1'b0;
      r_pred_ghr   <= '0;
    end else begin
      if (upd_valid_i) r_ctr[w_upd_idx] <= w_upd_new;
      r_ghr        <= w_ghr_next;
      r_resp_valid <= pred_valid_i;
      if (pred_valid_i) begin
        r_taken    <= w_pred_taken;
        r_pred_ghr <= r_ghr;
      end
    end
  end

  assign pred_resp_valid_o = r_resp_valid;
  assign pred_taken_o      = r_taken;
  assign pred_ghr_o        = r_pred_ghr;

  assign w_unused = ^{pred_pc_i, upd_pc_i, w_pred_ctr};

endmodule

// File: tb/tb_gshare_bht.sv
// Randomized scoreboard bench for gshare_bht against an arithmetic reference model.
module tb_gshare_bht;

  localparam int GHR_W = 8;
  localparam int W     = 16 + 1 + GHR_W;

  logic             clk;
  logic             rst;
  logic             pred_valid_i;
  logic [31:0]      pred_pc_i;
  logic             pred_resp_valid_o;
  logic             pred_taken_o;
  logic [GHR_W-1:0] pred_ghr_o;
  logic             upd_valid_i;
  logic [31:0]      upd_pc_i;
  logic [GHR_W-1:0] upd_ghr_i;
  logic             upd_taken_i;
  logic             upd_mispred_i;

  gshare_bht dut (
    .clk(clk), .rst(rst),
    .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
    .pred_resp_valid_o(pred_resp_valid_o), .pred_taken_o(pred_taken_o), .pred_ghr_o(pred_ghr_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_ghr_i(upd_ghr_i),
    .upd_taken_i(upd_taken_i), .upd_mispred_i(upd_mispred_i)
  );

  // clock / reset bookkeeping
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   cyc = 0;
  logic after_rst = 1'b0;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    after_rst <= rst;
  end

  // scoreboard state: entry = {issue cycle[15:0], taken, ghr}
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  // reference model: counter values 0..3, history as an integer mod 256
  int mdl_ctr[256];
  int mdl_ghr;

  function automatic int midx(logic [31:0] pc, int h);
    return int'((pc >> 2) & 32'hFF) ^ h;
  endfunction

  function automatic int sat(int c, bit t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: applies one cycle of inputs and advances the model for that cycle
  task automatic drive(input bit r, input bit pv, input logic [31:0] ppc,
                       input bit uv, input logic [31:0] upc, input logic [7:0] ughr,
                       input bit ut, input bit um);
    int pi, ui, c, t;
    rst = r; pred_valid_i = pv; pred_pc_i = ppc;
    upd_valid_i = uv; upd_pc_i = upc; upd_ghr_i = ughr;
    upd_taken_i = ut; upd_mispred_i = um;
    if (r) begin
      for (int i = 0; i < 256; i++) mdl_ctr[i] = 1;
      mdl_ghr = 0;
    end else begin
      ui = midx(upc, int'(ughr));
      t  = 0;
      if (pv) begin
        pi = midx(ppc, mdl_ghr);
        c  = mdl_ctr[pi];
`ifdef GSHARE_BHT_WR_BYPASS_EN
        if (uv && ui == pi) c = sat(c, ut);
`endif
        t = (c >= 2) ? 1 : 0;
        exp_q.push_back({cyc[15:0], t[0], mdl_ghr[7:0]});
      end
      if (uv) mdl_ctr[ui] = sat(mdl_ctr[ui], ut);
      if (uv && um) mdl_ghr = (int'(ughr) * 2 + int'(ut)) % 256;
      else if (pv) mdl_ghr = (mdl_ghr * 2 + t) % 256;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
  endtask
  task automatic predict(input logic [31:0] pc);
    drive(1'b0, 1'b1, pc, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
  endtask
  task automatic update(input logic [31:0] pc, input logic [7:0] h, input bit t, input bit m);
    drive(1'b0, 1'b0, 32'h0, 1'b1, pc, h, t, m);
  endtask
  task automatic restore0();
    update(32'h3FC, 8'h00, 1'b0, 1'b1);
  endtask

  // monitor: pops on each response, checks held outputs otherwise
  logic [W-1:0] e;
  int hold_taken = 0;
  int hold_ghr   = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (after_rst) begin
        hold_taken = 0;
        hold_ghr   = 0;
      end
      if (pred_resp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_latency", (cyc - 1) & 32'hFFFF, int'(e[W-1 -: 16]));
          chk("pred_taken", int'(pred_taken_o), int'(e[GHR_W]));
          chk("pred_ghr", int'(pred_ghr_o), int'(e[GHR_W-1:0]));
          hold_taken = int'(e[GHR_W]);
          hold_ghr   = int'(e[GHR_W-1:0]);
        end
      end else begin
        if (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 16]) == ((cyc - 1) & 32'hFFFF)) begin
          chk("missing_resp", 0, 1);
          void'(exp_q.pop_front());
        end
        chk("hold_taken", int'(pred_taken_o), hold_taken);
        chk("hold_ghr", int'(pred_ghr_o), hold_ghr);
      end
    end
  end

  logic [31:0] r_pc, r_upc;
  logic [7:0]  r_ghr;

  initial begin
    rst = 1'b1; pred_valid_i = 1'b0; pred_pc_i = '0;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_ghr_i = '0;
    upd_taken_i = 1'b0; upd_mispred_i = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();
    mon_en = 1'b1;

    // reset-state prediction
    predict(32'h100);
    idle(); idle();

    // training, saturation at the top and no wrap at the bottom
    update(32'h100, 8'h00, 1'b1, 1'b0);
    update(32'h100, 8'h00, 1'b1, 1'b0);
    restore0();
    predict(32'h100);
    update(32'h100, 8'h00, 1'b1, 1'b0);
    restore0();
    predict(32'h100);
    for (int i = 0; i < 4; i++) update(32'h100, 8'h00, 1'b0, 1'b0);
    restore0();
    predict(32'h100);
    update(32'h100, 8'h00, 1'b1, 1'b0);
    restore0();
    predict(32'h100);
    idle();

    // back-to-back predicts with trained counters
    do_reset();
    for (int i = 0; i < 2; i++) begin
      update(32'h0, 8'h00, 1'b1, 1'b0);
      update(32'h4, 8'h01, 1'b1, 1'b0);
      update(32'h8, 8'h03, 1'b1, 1'b0);
    end
    restore0();
    predict(32'h0);
    predict(32'h4);
    predict(32'h8);
    predict(32'hC);

    // mispredict recovery in the same cycle as a predict
    drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h300, 8'h5A, 1'b1, 1'b1);
    predict(32'h40);
    idle();

    // same-index predict and taken update
    do_reset();
    drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 8'h00, 1'b1, 1'b0);
    restore0();
    predict(32'h40);
    idle();

    // reset with a request in flight, then counters back at weakly-not-taken
    update(32'h100, 8'h00, 1'b1, 1'b0);
    update(32'h100, 8'h00, 1'b1, 1'b0);
    restore0();
    predict(32'h100);
    drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 8'h00, 1'b1, 1'b1);
    idle();
    predict(32'h100);
    idle();

    // randomized traffic with narrow PC spread to force index collisions
    for (int n = 0; n < 3000; n++) begin
      r_pc  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      r_upc = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      r_ghr = 8'($urandom_range(0, 255));
      drive(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), r_pc,
            1'($urandom_range(0, 1)), r_upc, r_ghr,
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    idle(); idle(); idle();
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
